// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Round-robin arbiter that shares one external combinational 32-bit bitwise
// logic unit between two requesters. An accepted request's op/operands are
// latched onto the unit, the unit output is registered one cycle later and
// returned to the owner with a one-cycle done pulse.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   req0/op0/a0/b0         requester 0 request (held until done0), op, operands
//   req1/op1/a1/b1         requester 1 request (held until done1), op, operands
//   gnt0, gnt1             one-cycle accept pulses (high during EXEC)
//   done0, done1           one-cycle result-valid pulses (high during DONE)
//   result, zero           registered unit result and result == 0 flag
//   unit_op/unit_a/unit_b  latched op and operands driven to the shared unit
//   unit_y                 shared unit combinational output
//   busy                   high while a transaction is in EXEC or DONE
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [1:0]       unit_op,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    input  logic [WIDTH-1:0] unit_y,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             ptr_nxt;
    logic             owner;
    logic             owner_nxt;
    logic             win;
    logic             gnt0_nxt;
    logic             gnt1_nxt;
    logic             done0_nxt;
    logic             done1_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic             zero_nxt;
    logic [1:0]       unit_op_nxt;
    logic [WIDTH-1:0] unit_a_nxt;
    logic [WIDTH-1:0] unit_b_nxt;
    logic             busy_nxt;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            unit_op <= 2'b00;
            unit_a  <= '0;
            unit_b  <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            gnt0    <= gnt0_nxt;
            gnt1    <= gnt1_nxt;
            done0   <= done0_nxt;
            done1   <= done1_nxt;
            result  <= result_nxt;
            zero    <= zero_nxt;
            unit_op <= unit_op_nxt;
            unit_a  <= unit_a_nxt;
            unit_b  <= unit_b_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state, arbitration and output decode
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        win         = 1'b0;
        gnt0_nxt    = 1'b0;
        gnt1_nxt    = 1'b0;
        done0_nxt   = 1'b0;
        done1_nxt   = 1'b0;
        result_nxt  = result;
        zero_nxt    = zero;
        unit_op_nxt = unit_op;
        unit_a_nxt  = unit_a;
        unit_b_nxt  = unit_b;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to ptr; otherwise the lone requester wins.
                    win         = (req0 && req1) ? ptr : req1;
                    owner_nxt   = win;
                    unit_op_nxt = win ? op1 : op0;
                    unit_a_nxt  = win ? a1 : a0;
                    unit_b_nxt  = win ? b1 : b0;
                    gnt0_nxt    = ~win;
                    gnt1_nxt    = win;
                    state_nxt   = EXEC;
                end
            end
            EXEC: begin
                result_nxt = unit_y;
                zero_nxt   = (unit_y == '0);
                done0_nxt  = ~owner;
                done1_nxt  = owner;
                // Prefer the other requester at the next contention.
                ptr_nxt    = ~owner;
                state_nxt  = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter: a stimulus process issues requests and
// pushes expected results into per-requester queues; a monitor process keeps
// a cycle-level reference of the arbitration rules and compares every cycle.
module tb_logic_unit_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             req0;
    logic [1:0]       op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [1:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [1:0]       unit_op;
    logic [WIDTH-1:0] unit_a;
    logic [WIDTH-1:0] unit_b;
    logic [WIDTH-1:0] unit_y;
    logic             busy;

    logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .op0     (op0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .op1     (op1),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .result  (result),
        .zero    (zero),
        .unit_op (unit_op),
        .unit_a  (unit_a),
        .unit_b  (unit_b),
        .unit_y  (unit_y),
        .busy    (busy)
    );

    // Bitwise logic function: 00 AND, 01 OR, 10 XOR, 11 NOR
    function automatic logic [WIDTH-1:0] lu(input logic [1:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // The shared external unit
    assign unit_y = lu(unit_op, unit_a, unit_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  fin   = 1'b0;
    bit  act[2];
    bit  cont[2];
    bit  granted[2];

    // ---------------- monitor / reference model ----------------
    initial begin : monitor
        int               cyc;
        bit               has_g;
        int               last_g;
        bit               own_m;
        bit               ptr_m;
        bit               rp0;
        bit               rp1;
        logic [WIDTH-1:0] held;
        bit               held_z;
        bit               free;
        bit               eg;
        bit               ed;
        bit               w;
        logic [1:0]       exp2;
        bit               exp_busy;
        bit               fin_done;
        cyc = 0; has_g = 0; last_g = 0; own_m = 0; ptr_m = 0;
        rp0 = 0; rp1 = 0; held = '0; held_z = 0; fin_done = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                n_cmp++;
                if (gnt0 || gnt1 || done0 || done1 || busy || zero || unit_op != 2'b00 ||
                    result != '0 || unit_a != '0 || unit_b != '0) begin
                    n_bad++;
                    $display("FAIL reset_outputs: got gnt=%b%b done=%b%b busy=%b zero=%b op=%b res=%h a=%h b=%h, want all 0",
                             gnt1, gnt0, done1, done0, busy, zero, unit_op, result, unit_a, unit_b);
                end
                has_g = 0; ptr_m = 0; held = '0; held_z = 0;
                rp0 = 0; rp1 = 0;
            end else begin
                free = !has_g || (cyc - last_g >= 3);
                eg   = free && (rp0 || rp1);
                w    = (rp0 && rp1) ? ptr_m : rp1;
                ed   = has_g && (cyc == last_g + 1);

                exp2 = eg ? (w ? 2'b10 : 2'b01) : 2'b00;
                n_cmp++;
                if ({gnt1, gnt0} != exp2) begin
                    n_bad++;
                    $display("FAIL grant cyc=%0d: got %b want %b", cyc, {gnt1, gnt0}, exp2);
                end
                if (eg) begin
                    has_g = 1; last_g = cyc; own_m = w;
                end

                exp2 = ed ? (own_m ? 2'b10 : 2'b01) : 2'b00;
                n_cmp++;
                if ({done1, done0} != exp2) begin
                    n_bad++;
                    $display("FAIL done cyc=%0d: got %b want %b", cyc, {done1, done0}, exp2);
                end
                if (ed) begin
                    ptr_m = ~own_m;
                    if ((own_m ? q1.size() : q0.size()) == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL scoreboard cyc=%0d: got done for %0d, want a queued request", cyc, own_m);
                    end else begin
                        held   = own_m ? q1.pop_front() : q0.pop_front();
                        held_z = (held == '0);
                    end
                end

                n_cmp++;
                if (result != held || zero != held_z) begin
                    n_bad++;
                    $display("FAIL result cyc=%0d: got %h zero=%b want %h zero=%b", cyc, result, zero, held, held_z);
                end

                exp_busy = has_g && (cyc - last_g <= 1);
                n_cmp++;
                if (busy != exp_busy) begin
                    n_bad++;
                    $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, exp_busy);
                end

                if (fin && !fin_done) begin
                    fin_done = 1;
                    n_cmp++;
                    if (q0.size() != 0 || q1.size() != 0) begin
                        n_bad++;
                        $display("FAIL leftover: got %0d/%0d queued want 0/0", q0.size(), q1.size());
                    end
                end
            end
            rp0 = req0; rp1 = req1;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int r, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (r == 0) begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
            q0.push_back(lu(op, a, b));
        end else begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
            q1.push_back(lu(op, a, b));
        end
        act[r] = 1'b1;
        granted[r] = 1'b0;
    endtask

    task automatic issue_rand(input int r);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? ~a : WIDTH'($urandom);
        if ($urandom_range(0, 5) == 0) b = a;
        issue(r, 2'($urandom_range(0, 3)), a, b);
    endtask

    // Advance one cycle; retire finished transactions and note grants.
    task automatic step();
        @(posedge clk);
        #1;
        if (act[0] && done0) begin
            if (cont[0]) issue_rand(0);
            else begin req0 = 1'b0; act[0] = 1'b0; end
        end
        if (act[1] && done1) begin
            if (cont[1]) issue_rand(1);
            else begin req1 = 1'b0; act[1] = 1'b0; end
        end
        if (gnt0) granted[0] = 1'b1;
        if (gnt1) granted[1] = 1'b1;
    endtask

    task automatic drain();
        cont[0] = 1'b0; cont[1] = 1'b0;
        for (int i = 0; i < 30 && (act[0] || act[1]); i++) step();
        if (act[0] || act[1]) begin
            req0 = 1'b0; req1 = 1'b0; act[0] = 1'b0; act[1] = 1'b0;
            q0.delete(); q1.delete();
        end
        step();
    endtask

    initial begin : stim
        reset = 1'b1;
        req0 = 1'b0; op0 = 2'b00; a0 = '0; b0 = '0;
        req1 = 1'b0; op1 = 2'b00; a1 = '0; b1 = '0;
        act[0] = 0; act[1] = 0; cont[0] = 0; cont[1] = 0;
        granted[0] = 0; granted[1] = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // NOR from requester 0: expect F000FFF0
        issue(0, 2'b11, 32'h0F0F0000, 32'h00F0000F);
        drain();

        // AND from requester 1: expect zero result
        issue(1, 2'b00, 32'hFFFF0000, 32'h0000FFFF);
        drain();

        // Both requesters continuously: grants alternate
        cont[0] = 1'b1; cont[1] = 1'b1;
        issue_rand(0);
        issue_rand(1);
        repeat (14) step();
        drain();

        // req1 raised during requester 0's EXEC cycle
        issue_rand(0);
        step();
        issue_rand(1);
        drain();

        // Operands changed after acceptance
        issue(0, 2'b01, 32'h1234_0000, 32'h0000_5678);
        step();
        a0 = 32'hDEAD_BEEF; b0 = 32'hFFFF_FFFF; op0 = 2'b10;
        drain();

        // Reset during EXEC (ptr is 1 here after requester 0's last done)
        issue_rand(0);
        step();
        #2 reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; act[0] = 0; act[1] = 0;
        q0.delete(); q1.delete();
        @(negedge clk);
        #1 reset = 1'b0;
        step();
        issue_rand(1);
        issue_rand(0);
        drain();

        // Random traffic, including operand scrambling after acceptance
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                cont[r] = ($urandom_range(0, 3) == 0);
                if (!act[r] && $urandom_range(0, 2) == 0) issue_rand(r);
                else if (act[r] && granted[r] && $urandom_range(0, 1) == 0) begin
                    if (r == 0) begin a0 = $urandom; b0 = $urandom; end
                    else begin a1 = $urandom; b1 = $urandom; end
                end
            end
            step();
        end
        drain();

        fin = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one external combinational 32-bit bitwise logic unit (AND/OR/XOR/NOR slices) between two requesters.
- Arbitration is round-robin. Each accepted request's operands are latched and driven onto the shared unit.
- The unit output is registered and returned to the granted requester with a one-cycle done pulse.
- Sits between the two requesting datapath stages and the shared logic unit.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request; held high until done0
- op0  input  2  requester 0 op: 00 AND, 01 OR, 10 XOR, 11 NOR
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- req1  input  1  requester 1 request
- op1  input  2  requester 1 op
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- gnt0  output  1  one-cycle pulse: requester 0 accepted, operands latched
- gnt1  output  1  one-cycle pulse: requester 1 accepted
- done0  output  1  one-cycle pulse: result valid for requester 0
- done1  output  1  one-cycle pulse: result valid for requester 1
- result  output  WIDTH  registered result; valid while done0/done1 high, held otherwise
- zero  output  1  registered, result == 0
- unit_op  output  2  op driven to shared unit
- unit_a  output  WIDTH  operand A driven to shared unit
- unit_b  output  WIDTH  operand B driven to shared unit
- unit_y  input  WIDTH  shared unit combinational output
- busy  output  1  high in EXEC and DONE

Behaviour:
- Reset (async, any state, mid-transaction included):
  - State goes to IDLE; ptr=0 (requester 0 preferred).
  - gnt0/gnt1/done0/done1/busy=0; result=0; zero=0; unit_op=00; unit_a=unit_b=0; owner=0.
  - An in-flight transaction is discarded; no done is produced for it.
- FSM, three states:
  - IDLE: on a clock edge with req0|req1 high, choose the winner, then:
    - latch winner's op/a/b into unit_op/unit_a/unit_b and set owner;
    - assert that requester's gnt for the following cycle;
    - go to EXEC.
    - With no request, stay in IDLE; unit_* registers hold their previous values.
  - EXEC: unit_* stable and unit_y settles. At the edge:
    - result <= unit_y; zero <= (unit_y == 0);
    - assert done[owner] for the following cycle;
    - ptr <= ~owner;
    - go to DONE.
  - DONE: done[owner]=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Winner selection:
  - Only one request high: that requester wins.
  - Both high: requester ptr wins.
  - ptr changes only at EXEC->DONE.
- Outputs:
  - gnt pulse is high during the EXEC cycle; done pulse is high during the DONE cycle.
  - busy = (state != IDLE).
- Latency:
  - Request seen at edge T: gnt in cycle T..T+1, done in cycle T+1..T+2.
  - Next arbitration edge is T+3, so throughput is one transaction per 3 cycles.
- Handshake:
  - Operands need be valid only at the accepting edge; latched thereafter.
  - A requester must keep req high until its done and drop it in the done cycle.
  - If req is still high at the IDLE edge after done, it is treated as a new request. Rotation still applies.
- Requests arriving during EXEC/DONE wait; no loss, no queueing beyond the held req level.
- Result width is exactly WIDTH; no arithmetic, no carry. The op field is passed through unmodified.
- Starvation: with both requesting continuously, grants alternate 0,1,0,1...

Test Plan:
- Reset then req0=1, op0=11, a0=32'h0F0F0000, b0=32'h00F0000F, with the unit modelled as bitwise NOR:
  - gnt0 pulse in the cycle after the accepting edge, done0 one cycle later;
  - result=32'hF000FFF0, zero=0, busy high for 2 cycles.
- req1 only, op1=00, a1=32'hFFFF0000, b1=32'h0000FFFF (AND model):
  - done1 pulse; result=0, zero=1; done0 never asserts.
- req0 and req1 held high continuously with distinct operands:
  - grant order 0,1,0,1 over 12 cycles; each done matches its owner's expected result.
- Assert req1 in the EXEC cycle of a requester-0 transaction:
  - requester 0 completes unaffected;
  - req1 is accepted at the first IDLE edge, 3 cycles after req0's accept.
- Assert reset during EXEC:
  - all outputs 0 immediately (async), no done pulse;
  - after release with req1 and req0 both high, requester 0 wins (ptr=0).
- Change a0/b0 after the accept edge while req0 is held:
  - result reflects the operands latched at acceptance, not the changed values.
